ibex_data_sram_bridge: RTL

- Data-side memory slave sitting directly downstream of the load/store unit.
- Accepts the LSU req/gnt/rvalid data protocol with up to 2 outstanding transactions and drives a single-port synchronous SRAM (1-cycle read latency) with programmable wait states.
- Returns rdata/err on rvalid. Out-of-range accesses are answered with an error and never touch the SRAM.

---
 rtl/ibex_data_bridge_pkg.sv | 19 +
 rtl/ibex_bridge_resp_queue.sv | 55 +++++
 rtl/ibex_data_sram_bridge.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ibex_data_bridge_pkg.sv
// Shared types and constants for the LSU data-side SRAM bridge.
//   bridge_fsm_e       : grant FSM states
//   resp_entry_t       : per-transaction response record kept until rvalid
//   BRIDGE_QUEUE_DEPTH : response queue depth (covers MAX_OUTSTANDING up to 2)
package ibex_data_bridge_pkg;

    localparam int unsigned BRIDGE_QUEUE_DEPTH = 2;

    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_WAIT = 1'b1
    } bridge_fsm_e;

    typedef struct packed {
        logic err;
        logic we;
    } resp_entry_t;

endpackage

// File: rtl/ibex_bridge_resp_queue.sv
// Two-entry in-order FIFO of response records.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the queue)
//   push, data   : enqueue data (accepted when not full, or full and popping)
//   pop          : dequeue head (ignored when empty)
//   head         : current head entry; empty / full : occupancy flags
module ibex_bridge_resp_queue
    import ibex_data_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  resp_entry_t data,
    input  logic        pop,
    output resp_entry_t head,
    output logic        empty,
    output logic        full
);

    localparam int unsigned CW = $clog2(BRIDGE_QUEUE_DEPTH + 1);

    resp_entry_t   mem_q [BRIDGE_QUEUE_DEPTH];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(BRIDGE_QUEUE_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    // Storage and pointers; depth 2 lets each pointer be a single toggling bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BRIDGE_QUEUE_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ibex_data_sram_bridge.sv
// LSU data-side slave driving a single-port synchronous SRAM (1-cycle read).
// Grants after WAIT_CYCLES, limits outstanding transactions to MAX_OUTSTANDING,
// answers out-of-window accesses with err and never touches the SRAM for them.
// Build option: BRIDGE_RESP_REG_EN adds an output register on rvalid/rdata/err
// (rvalid 2 cycles after gnt instead of 1).
//   clk_i, rst_i           : clock, synchronous active-high reset
//   data_req/gnt/rvalid/err: LSU handshake and response
//   data_addr/we/be/wdata  : request payload (sampled in the gnt cycle only)
//   data_rdata_o           : load data, 0 for stores and errors
//   sram_*                 : SRAM strobe, write enable, word index, byte mask, data
module ibex_data_sram_bridge
    import ibex_data_bridge_pkg::*;
#(
    parameter logic [31:0]      ADDR_BASE       = 32'h0010_0000,
    parameter int unsigned      MEM_WORDS       = 4096,
    parameter int unsigned      WAIT_CYCLES     = 1,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    localparam int unsigned     AW              = $clog2(MEM_WORDS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic                data_err_o,
    input  logic [31:0]         data_addr_i,
    input  logic                data_we_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_wdata_i,
    output logic [31:0]         data_rdata_o,
    output logic                sram_req_o,
    output logic                sram_we_o,
    output logic [AW-1:0]       sram_addr_o,
    output logic [3:0]          sram_be_o,
    output logic [31:0]         sram_wdata_o,
    input  logic [31:0]         sram_rdata_i
);

    localparam int unsigned      CNT_W     = 3;
    localparam int unsigned      OUT_W     = 2;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    // 33-bit window bounds so base + size cannot wrap.
    localparam logic [32:0]      WIN_LO    = {1'b0, ADDR_BASE};
    localparam logic [32:0]      WIN_HI    = WIN_LO + 33'(4 * MEM_WORDS);

    bridge_fsm_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] outstanding_q;
    logic             gnt_c;
    logic             grant_ok_c;
    logic             in_range_c;
    logic             sram_req_c;
    logic [31:0]      offset_c;
    resp_entry_t      head_c;
    logic             empty_c;
    logic             full_c;
    logic             resp_valid_c;
    logic             resp_err_c;
    logic [31:0]      resp_rdata_c;

    assign in_range_c = ({1'b0, data_addr_i} >= WIN_LO) && ({1'b0, data_addr_i} < WIN_HI);
    assign offset_c   = data_addr_i - ADDR_BASE;
    // Registered count only; the queue-full term never bites while MAX_OUTSTANDING <= depth.
    assign grant_ok_c = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) & ~full_c & ~rst_i;

    // Grant FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant FSM next state and grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_c   = 1'b0;
        case (state_q)
            BR_IDLE: begin
                if (data_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt_c = grant_ok_c;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = BR_WAIT;
                    end
                end
            end
            BR_WAIT: begin
                if (!data_req_i) begin
                    // Request withdrawn before grant: abandon the wait.
                    state_d = BR_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (grant_ok_c) begin
                        gnt_c   = 1'b1;
                        state_d = BR_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = BR_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM side: everything held at 0 except in an in-range grant cycle.
    assign sram_req_c   = gnt_c & in_range_c;
    assign sram_req_o   = sram_req_c;
    assign sram_we_o    = sram_req_c & data_we_i;
    assign sram_addr_o  = sram_req_c ? AW'(offset_c >> 2) : '0;
    assign sram_be_o    = sram_req_c ? data_be_i : '0;
    assign sram_wdata_o = sram_req_c ? data_wdata_i : '0;
    assign data_gnt_o   = gnt_c;

    ibex_bridge_resp_queue u_resp_queue (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (gnt_c),
        .data  ('{err: ~in_range_c, we: data_we_i}),
        .pop   (resp_valid_c),
        .head  (head_c),
        .empty (empty_c),
        .full  (full_c)
    );

    // Head is always due the cycle after its grant, so it pops whenever present.
    assign resp_valid_c = ~empty_c & ~rst_i;
    assign resp_err_c   = resp_valid_c & head_c.err;
    assign resp_rdata_c = (resp_valid_c & ~head_c.err & ~head_c.we) ? sram_rdata_i : '0;

`ifdef BRIDGE_RESP_REG_EN
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    // Extra response stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= resp_valid_c;
            err_q    <= resp_err_c;
            rdata_q  <= resp_rdata_c;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;
`else
    assign data_rvalid_o = resp_valid_c;
    assign data_err_o    = resp_err_c;
    assign data_rdata_o  = resp_rdata_c;
`endif

    // Granted-but-unanswered count, retired on the rvalid actually presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_q + OUT_W'(gnt_c) - OUT_W'(data_rvalid_o);
        end
    end

endmodule
